fir_requant: RTL and testbench
==============================

Name: fir_requant

Overview:
- Sits directly downstream of the serial 4-MAC symmetric FIR. Takes its 27-bit accumulated output, one strobe per output sample.
- Rounds and scales the sample back to 12-bit signed, saturates it, and buffers it in a small first-word-fall-through FIFO with a valid/ready handshake to the next stage (DAC formatter / decimator).
- Keeps sticky status for saturation and FIFO overflow so that gain problems and back-pressure problems are visible to firmware.

Parameters:
- IN_WIDTH, 27, input sample width (signed two's complement).
- OUT_WIDTH, 12, output sample width (signed).
- SHIFT, 11, arithmetic right shift after rounding. The coefficient sum is 2*(41+132+341+510) = 2048, so 11 gives unity DC gain.
- FIFO_DEPTH, 4, output FIFO entries (power of 2, minimum 2).
- CNT_WIDTH, 8, width of the saturation event counter.

Ports:
- clk  in  1  single system clock (same clock as the FIR, which is 5x the sample rate).
- rst  in  1  synchronous, active-high reset.
- din  in  IN_WIDTH  FIR accumulator output, signed.
- din_vld  in  1  one-cycle strobe: din holds a new sample.
- dout  out  OUT_WIDTH  rounded, saturated sample at the FIFO head.
- dout_vld  out  1  FIFO not empty.
- dout_rdy  in  1  consumer accepts dout this cycle.
- clr_stat  in  1  one-cycle clear of all status.
- sat_flag  out  1  sticky: at least one sample has saturated.
- ovf_flag  out  1  sticky: at least one sample was dropped on a full FIFO.
- sat_cnt  out  CNT_WIDTH  count of saturation events, holds at all-ones.

Behaviour:
- Reset: when rst=1 at a clk edge, all registers clear.
  - dout=0, dout_vld=0, sat_flag=0, ovf_flag=0, sat_cnt=0.
  - FIFO pointers and fill count go to 0; pipeline valid bits go to 0.
  - Reset mid-operation discards all buffered and in-flight samples.
- Stage 1 (edge k, when din_vld=1):
  - r1 <= sign-extend(din) to IN_WIDTH+1 bits, plus 2^(SHIFT-1). This is round-half-up toward +infinity.
  - v1 <= din_vld.
- Stage 2 (edge k+1):
  - t = r1 >>> SHIFT (arithmetic shift).
  - If t > 2^(OUT_WIDTH-1)-1, s2 = 2047. If t < -2^(OUT_WIDTH-1), s2 = -2048. Otherwise s2 = t[OUT_WIDTH-1:0].
  - sat2 = v1 AND clipped. v2 <= v1.
- Stage 3 (edge k+2): if v2=1, push s2 into the FIFO.
  - The earliest dout_vld=1 is after edge k+2 (FIFO previously empty). Latency is 3 clocks from din_vld to dout_vld.
- FIFO pop: dout_vld=1 AND dout_rdy=1 at an edge pops the head. dout is combinationally the head entry. dout holds its value while dout_vld=1 and dout_rdy=0.
- Full with push only: the sample is dropped, contents are unchanged, and ovf_flag <= 1.
- Full with simultaneous push and pop: both succeed, no drop, count stays at FIFO_DEPTH.
- Empty with push: dout_vld rises the next cycle. A pop while empty is ignored.
- Pointers wrap modulo FIFO_DEPTH.
- Status:
  - sat2=1 sets sat_flag and increments sat_cnt unless sat_cnt is all-ones, in which case it holds.
  - A dropped sample that also saturated updates both the sat and ovf status.
- clr_stat=1 zeroes sat_flag, ovf_flag and sat_cnt. If an event occurs in the same cycle, the event wins over the clear: the flag is 1 and the count is 1.
- din_vld spacing: back-to-back strobes must be supported at full throughput (1 per clock), even though the FIR strobes only every 5 clocks.

Test Plan:
- Rounding (SHIFT=11, dout_rdy=1):
  - din = 1023, 1024, 2048, -1024, -1025 -> dout = 0, 1, 1, 0, -1 (0xFFF).
  - Each dout_vld pulse appears exactly 3 clocks after its din_vld.
- Saturation:
  - din = 4192256 -> dout = 2047, sat_flag stays 0.
  - din = 4193280 -> dout = 2047, sat_flag = 1, sat_cnt = 1.
  - din = -67108864 -> dout = -2048 (0x800), sat_cnt = 2.
- Back-pressure and overflow:
  - With dout_rdy=0, push samples 1..5 -> dout_vld=1, dout=1, ovf_flag=1 after the 5th.
  - Then dout_rdy=1 -> dout sequence 1, 2, 3, 4, then dout_vld=0.
- Full with simultaneous push and pop:
  - Fill with 4 samples, then assert dout_rdy=1 in the same cycle the 5th sample is pushed -> no overflow, the 5th sample is eventually output.
- Status clear:
  - After sat_cnt = 255, further saturations hold it at 255.
  - clr_stat in the same cycle as a saturation event -> sat_cnt = 1, sat_flag = 1.
  - clr_stat alone -> all status 0.
- Reset mid-stream:
  - Assert rst with 3 samples buffered and 2 in flight -> the next cycle dout_vld = 0 and all status is 0.
  - No stale sample emerges afterwards.

Source files
------------

// File: rtl/fir_requant.sv
// Requantizer behind the symmetric FIR: round-half-up, arithmetic shift and saturate to OUT_WIDTH.
// Buffers samples in a small FWFT FIFO and keeps sticky saturation and overflow status.
module fir_requant #(
    parameter int IN_WIDTH   = 27,
    parameter int OUT_WIDTH  = 12,
    parameter int SHIFT      = 11,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [IN_WIDTH-1:0]  din,
    input  logic                 din_vld,
    output logic [OUT_WIDTH-1:0] dout,
    output logic                 dout_vld,
    input  logic                 dout_rdy,
    input  logic                 clr_stat,
    output logic                 sat_flag,
    output logic                 ovf_flag,
    output logic [CNT_WIDTH-1:0] sat_cnt
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int RW = IN_WIDTH + 1;

    localparam logic signed [RW-1:0]  ROUND   = RW'(2 ** (SHIFT - 1));
    localparam logic signed [RW-1:0]  SAT_HI  = RW'(2 ** (OUT_WIDTH - 1) - 1);
    localparam logic signed [RW-1:0]  SAT_LO  = RW'(-(2 ** (OUT_WIDTH - 1)));
    localparam logic [OUT_WIDTH-1:0]  OUT_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    localparam logic [OUT_WIDTH-1:0]  OUT_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};
    localparam logic [AW:0]           FULL_CNT = (AW+1)'(FIFO_DEPTH);

    logic signed [RW-1:0]  r1;
    logic signed [RW-1:0]  t;
    logic                  v1;
    logic [OUT_WIDTH-1:0]  s2;
    logic [OUT_WIDTH-1:0]  s2_next;
    logic                  v2;
    logic                  clip;
    logic                  sat2;

    logic [OUT_WIDTH-1:0]  mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [AW:0]           count;
    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  pop;
    logic                  drop;

    // The extra MSB keeps the rounding add from wrapping at the positive input limit.
    assign t = r1 >>> SHIFT;

    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    always_comb begin
        s2_next = t[OUT_WIDTH-1:0];
        clip    = 1'b0;
        if (t > SAT_HI) begin
            s2_next = OUT_MAX;
            clip    = 1'b1;
        end else if (t < SAT_LO) begin
            s2_next = OUT_MIN;
            clip    = 1'b1;
        end
    end

    assign sat2 = v1 & clip;

    // NOTE: non-blocking assignments in clocked blocks so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r1 <= '0;
            v1 <= 1'b0;
            s2 <= '0;
            v2 <= 1'b0;
        end else begin
            v1 <= din_vld;
            if (din_vld) begin
                r1 <= {din[IN_WIDTH-1], din} + ROUND;
            end
            v2 <= v1;
            s2 <= s2_next;
        end
    end

    assign empty = (count == '0);
    assign full  = (count == FULL_CNT);
    assign pop   = ~empty & dout_rdy;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push  = v2 & (~full | pop);
    assign drop  = v2 & full & ~pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage has no reset; entries are only observable while count says they are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= s2;
        end
    end

    assign dout_vld = ~empty;
    assign dout     = empty ? '0 : mem[rd_ptr];

    // An event in the same cycle as clr_stat wins, leaving the flag set and the count at one.
    always_ff @(posedge clk) begin
        if (rst) begin
            sat_flag <= 1'b0;
            sat_cnt  <= '0;
            ovf_flag <= 1'b0;
        end else begin
            if (sat2) begin
                sat_flag <= 1'b1;
                if (clr_stat) begin
                    sat_cnt <= CNT_WIDTH'(1);
                end else if (~&sat_cnt) begin
                    sat_cnt <= sat_cnt + CNT_WIDTH'(1);
                end
            end else if (clr_stat) begin
                sat_flag <= 1'b0;
                sat_cnt  <= '0;
            end

            if (drop) begin
                ovf_flag <= 1'b1;
            end else if (clr_stat) begin
                ovf_flag <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fir_requant.sv
// Bench for fir_requant: directed vector table, hand-written corner sequences and a
// randomized run, all compared every cycle against a sample-level queue model.
module tb_fir_requant;

    localparam int IN_WIDTH   = 27;
    localparam int OUT_WIDTH  = 12;
    localparam int SHIFT      = 11;
    localparam int FIFO_DEPTH = 4;
    localparam int CNT_WIDTH  = 8;
    localparam int CNT_MAX    = 255;

    logic                 clk;
    logic                 rst;
    logic [IN_WIDTH-1:0]  din;
    logic                 din_vld;
    logic [OUT_WIDTH-1:0] dout;
    logic                 dout_vld;
    logic                 dout_rdy;
    logic                 clr_stat;
    logic                 sat_flag;
    logic                 ovf_flag;
    logic [CNT_WIDTH-1:0] sat_cnt;

    fir_requant #(
        .IN_WIDTH   (IN_WIDTH),
        .OUT_WIDTH  (OUT_WIDTH),
        .SHIFT      (SHIFT),
        .FIFO_DEPTH (FIFO_DEPTH),
        .CNT_WIDTH  (CNT_WIDTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .din      (din),
        .din_vld  (din_vld),
        .dout     (dout),
        .dout_vld (dout_vld),
        .dout_rdy (dout_rdy),
        .clr_stat (clr_stat),
        .sat_flag (sat_flag),
        .ovf_flag (ovf_flag),
        .sat_cnt  (sat_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int edge_no;
        int q;
        bit sat;
    } flight_t;

    flight_t fl[$];
    int      mq[$];
    int      edge_no = 0;
    bit      m_sat_flag = 0;
    bit      m_ovf_flag = 0;
    int      m_sat_cnt  = 0;

    // Value the sample ends up as: floor((x + 2^(SHIFT-1)) / 2^SHIFT), clipped to OUT_WIDTH.
    function automatic void quant(input longint x, output int q, output bit sat);
        longint den = longint'(1) << SHIFT;
        longint v   = x + (den / 2);
        longint f   = v / den;
        longint hi  = (longint'(1) << (OUT_WIDTH - 1)) - 1;
        longint lo  = -(longint'(1) << (OUT_WIDTH - 1));
        if ((v % den) != 0 && v < 0) f = f - 1;
        sat = 1'b0;
        if (f > hi) begin
            f = hi;
            sat = 1'b1;
        end else if (f < lo) begin
            f = lo;
            sat = 1'b1;
        end
        q = int'(f);
    endfunction

    task automatic model_edge();
        bit sat_ev;
        bit push_ev;
        bit drop_ev;
        bit pop_ev;
        int pv;
        edge_no++;
        if (rst) begin
            fl.delete();
            mq.delete();
            m_sat_flag = 0;
            m_ovf_flag = 0;
            m_sat_cnt  = 0;
            return;
        end
        sat_ev  = 0;
        push_ev = 0;
        drop_ev = 0;
        pv      = 0;
        foreach (fl[i]) begin
            if (fl[i].edge_no == edge_no - 1 && fl[i].sat) sat_ev = 1;
            if (fl[i].edge_no == edge_no - 2) begin
                push_ev = 1;
                pv      = fl[i].q;
            end
        end
        pop_ev = (mq.size() > 0) && dout_rdy;
        if (pop_ev) void'(mq.pop_front());
        if (push_ev) begin
            if (mq.size() < FIFO_DEPTH) mq.push_back(pv);
            else drop_ev = 1;
        end
        if (sat_ev) begin
            m_sat_flag = 1;
            if (clr_stat) m_sat_cnt = 1;
            else if (m_sat_cnt < CNT_MAX) m_sat_cnt++;
        end else if (clr_stat) begin
            m_sat_flag = 0;
            m_sat_cnt  = 0;
        end
        if (drop_ev) m_ovf_flag = 1;
        else if (clr_stat) m_ovf_flag = 0;
        while (fl.size() > 0 && fl[0].edge_no <= edge_no - 2) void'(fl.pop_front());
        if (din_vld) begin
            flight_t f;
            longint  xs;
            xs = longint'($signed(din));
            f.edge_no = edge_no;
            quant(xs, f.q, f.sat);
            fl.push_back(f);
        end
    endtask

    task automatic auto_compare();
        logic [OUT_WIDTH-1:0] exp_dout;
        exp_dout = (mq.size() > 0) ? OUT_WIDTH'(mq[0]) : '0;
        check("model dout_vld", 32'(dout_vld), 32'(mq.size() > 0));
        check("model dout", 32'(dout), 32'(exp_dout));
        check("model sat_flag", 32'(sat_flag), 32'(m_sat_flag));
        check("model ovf_flag", 32'(ovf_flag), 32'(m_ovf_flag));
        check("model sat_cnt", 32'(sat_cnt), 32'(m_sat_cnt));
    endtask

    // Inputs are stable across the edge; the model consumes them, outputs are sampled 1 ns later.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        auto_compare();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        din_vld = 1'b0;
        clr_stat = 1'b0;
        step();
        rst = 1'b0;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [IN_WIDTH-1:0]  din;
        logic [OUT_WIDTH-1:0] dout;
        logic                 sat_flag;
        logic [CNT_WIDTH-1:0] sat_cnt;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{IN_WIDTH'(1023),      12'h000, 1'b0, 8'd0};
        vecs[1] = '{IN_WIDTH'(1024),      12'h001, 1'b0, 8'd0};
        vecs[2] = '{IN_WIDTH'(2048),      12'h001, 1'b0, 8'd0};
        vecs[3] = '{IN_WIDTH'(-1024),     12'h000, 1'b0, 8'd0};
        vecs[4] = '{IN_WIDTH'(-1025),     12'hFFF, 1'b0, 8'd0};
        vecs[5] = '{IN_WIDTH'(4192256),   12'h7FF, 1'b0, 8'd0};
        vecs[6] = '{IN_WIDTH'(4193280),   12'h7FF, 1'b1, 8'd1};
        vecs[7] = '{IN_WIDTH'(-67108864), 12'h800, 1'b1, 8'd2};

        rst = 1'b1;
        din = '0;
        din_vld = 1'b0;
        dout_rdy = 1'b0;
        clr_stat = 1'b0;
        step();
        step();
        rst = 1'b0;
        check("reset dout_vld", 32'(dout_vld), 32'd0);
        check("reset dout", 32'(dout), 32'd0);
        check("reset sat_flag", 32'(sat_flag), 32'd0);
        check("reset ovf_flag", 32'(ovf_flag), 32'd0);
        check("reset sat_cnt", 32'(sat_cnt), 32'd0);

        // Rounding and saturation, one sample at a time, with a 3-clock latency check.
        dout_rdy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            din = vecs[i].din;
            din_vld = 1'b1;
            step();
            din_vld = 1'b0;
            check("latency vld after 1", 32'(dout_vld), 32'd0);
            step();
            check("latency vld after 2", 32'(dout_vld), 32'd0);
            step();
            check("latency vld after 3", 32'(dout_vld), 32'd1);
            check("vec dout", 32'(dout), 32'(vecs[i].dout));
            check("vec sat_flag", 32'(sat_flag), 32'(vecs[i].sat_flag));
            check("vec sat_cnt", 32'(sat_cnt), 32'(vecs[i].sat_cnt));
            step();
            check("vec popped", 32'(dout_vld), 32'd0);
        end

        // Back-pressure: five back-to-back samples into a four-entry FIFO.
        do_reset();
        dout_rdy = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            din = IN_WIDTH'(i * 2048);
            din_vld = 1'b1;
            step();
        end
        din_vld = 1'b0;
        step();
        step();
        check("bp dout_vld", 32'(dout_vld), 32'd1);
        check("bp dout head", 32'(dout), 32'd1);
        check("bp ovf_flag", 32'(ovf_flag), 32'd1);
        dout_rdy = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            check("bp drain", 32'(dout), 32'(i));
            step();
        end
        check("bp empty", 32'(dout_vld), 32'd0);

        // Full FIFO with push and pop on the same edge.
        do_reset();
        dout_rdy = 1'b0;
        for (int i = 10; i <= 14; i++) begin
            din = IN_WIDTH'(i * 2048);
            din_vld = 1'b1;
            step();
        end
        din_vld = 1'b0;
        step();
        check("pp full head", 32'(dout), 32'd10);
        dout_rdy = 1'b1;
        step();
        check("pp no ovf", 32'(ovf_flag), 32'd0);
        for (int i = 11; i <= 14; i++) begin
            check("pp drain", 32'(dout), 32'(i));
            step();
        end
        check("pp empty", 32'(dout_vld), 32'd0);

        // Saturation counter holds at all-ones.
        do_reset();
        dout_rdy = 1'b0;
        din = IN_WIDTH'(67108863);
        din_vld = 1'b1;
        for (int i = 0; i < 260; i++) step();
        din_vld = 1'b0;
        for (int i = 0; i < 3; i++) step();
        check("cnt hold", 32'(sat_cnt), 32'(CNT_MAX));
        check("cnt sat_flag", 32'(sat_flag), 32'd1);
        check("cnt ovf_flag", 32'(ovf_flag), 32'd1);

        // Clear coinciding with a saturation event: the event wins.
        din_vld = 1'b1;
        step();
        din_vld = 1'b0;
        clr_stat = 1'b1;
        step();
        clr_stat = 1'b0;
        check("clr+event sat_cnt", 32'(sat_cnt), 32'd1);
        check("clr+event sat_flag", 32'(sat_flag), 32'd1);
        check("clr+event ovf_flag", 32'(ovf_flag), 32'd0);
        dout_rdy = 1'b1;
        for (int i = 0; i < 6; i++) step();
        clr_stat = 1'b1;
        step();
        clr_stat = 1'b0;
        check("clr sat_cnt", 32'(sat_cnt), 32'd0);
        check("clr sat_flag", 32'(sat_flag), 32'd0);
        check("clr ovf_flag", 32'(ovf_flag), 32'd0);

        // Reset with three samples buffered and two in flight.
        do_reset();
        dout_rdy = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            din = (i == 3) ? IN_WIDTH'(67108863) : IN_WIDTH'(i * 2048);
            din_vld = 1'b1;
            step();
        end
        din_vld = 1'b0;
        check("pre-rst sat_flag", 32'(sat_flag), 32'd1);
        check("pre-rst dout_vld", 32'(dout_vld), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst dout_vld", 32'(dout_vld), 32'd0);
        check("rst sat_flag", 32'(sat_flag), 32'd0);
        check("rst sat_cnt", 32'(sat_cnt), 32'd0);
        check("rst ovf_flag", 32'(ovf_flag), 32'd0);
        dout_rdy = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            check("rst no stale", 32'(dout_vld), 32'd0);
        end

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            case ($urandom_range(0, 2))
                0:       din = IN_WIDTH'($urandom);
                1:       din = IN_WIDTH'(int'($urandom_range(0, 16383)) - 8192);
                default: din = ($urandom_range(0, 1) == 0)
                               ? IN_WIDTH'(4192256 + int'($urandom_range(0, 2047)))
                               : IN_WIDTH'(-4195840 + int'($urandom_range(0, 2047)));
            endcase
            din_vld  = ($urandom_range(0, 9) < 6);
            dout_rdy = ($urandom_range(0, 9) < 7);
            clr_stat = ($urandom_range(0, 31) == 0);
            step();
        end
        din_vld = 1'b0;
        clr_stat = 1'b0;
        dout_rdy = 1'b1;
        for (int i = 0; i < 8; i++) step();
        check("random drained", 32'(dout_vld), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
